tilemap_rom_arbiter: RTL

Shares the single 64-bit graphics ROM port among the tilemap layer fetchers (BG0–BG3 and later clients) of the scroll chip. Each requester raises a toggle-style request carrying a ROM address and a "blank tile" flag. The arbiter grants requesters round-robin and drives the toggle req/ack ROM handshake. It returns the fetched row to the requester as a one-cycle load pulse with an index, ready for the layer's tile shifter.

---
 rtl/tilemap_rom_arbiter_if.sv | 32 +++
 rtl/tilemap_rom_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/tilemap_rom_arbiter_if.sv
// Requester / ROM bundle for the tilemap ROM arbiter.
// The slave modport is the arbiter side. The master modport is the
// environment side, which covers the layer fetchers and the ROM.
interface tilemap_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_toggle;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_blank;
  logic [NUM_REQ-1:0]        ack_toggle;
  logic                      load;
  logic [IDX_W-1:0]          load_index;
  logic [DATA_W-1:0]         load_data;
  logic [ADDR_W-1:0]         rom_address;
  logic                      rom_req;
  logic                      rom_ack;
  logic [DATA_W-1:0]         rom_data;
  logic                      busy;

  modport slave (
    input  req_toggle, req_addr, req_blank, rom_ack, rom_data,
    output ack_toggle, load, load_index, load_data, rom_address, rom_req, busy
  );

  modport master (
    output req_toggle, req_addr, req_blank, rom_ack, rom_data,
    input  ack_toggle, load, load_index, load_data, rom_address, rom_req, busy
  );
endinterface

// File: rtl/tilemap_rom_arbiter.sv
// Round-robin arbiter that shares the 64-bit graphics ROM port among the
// tilemap layer fetchers. Requests use a toggle handshake. Blank tiles are
// answered with zero data and never reach the ROM.
module tilemap_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 64
) (
  input logic                  clk,
  input logic                  reset,
  tilemap_rom_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] pending;
  logic [IDX_W-1:0]   rr_q, cur_q, win;
  logic               found;
  logic               rom_match;
  logic               grant_blank, grant_fetch, complete;
  logic               load_q;
  logic [IDX_W-1:0]   load_index_q;
  logic [DATA_W-1:0]  load_data_q;
  logic [ADDR_W-1:0]  rom_address_q;
  // rom_req is deliberately left out of reset. A fetch that is still in
  // flight when reset arrives must finish against the same toggle phase.
  logic               rom_req_q = 1'b0;

  assign pending   = bus.req_toggle ^ ack_q;
  assign rom_match = (rom_req_q == bus.rom_ack);

  // Round-robin search that starts one past the last grant
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Next state. Reset lands in FLUSH when a ROM access is still outstanding.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = rom_match ? IDLE : FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (found && !bus.req_blank[win]) state_d = WAIT;
        WAIT:    if (rom_match) state_d = IDLE;
        FLUSH:   if (rom_match) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Actions taken this cycle, decoded from the current state
  always_comb begin
    grant_blank = 1'b0;
    grant_fetch = 1'b0;
    complete    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_blank = bus.req_blank[win];
          grant_fetch = !bus.req_blank[win];
        end
      end
      WAIT:    complete = rom_match;
      default: ;
    endcase
  end

  // Registered outputs, the pointer, and the captured grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q         <= '0;
      load_q        <= 1'b0;
      load_index_q  <= '0;
      load_data_q   <= '0;
      rom_address_q <= '0;
      rr_q          <= IDX_W'(NUM_REQ - 1);
      cur_q         <= '0;
    end else begin
      load_q <= 1'b0;
      if (grant_blank) begin
        ack_q[win]   <= ~ack_q[win];
        load_q       <= 1'b1;
        load_index_q <= win;
        load_data_q  <= '0;
        rr_q         <= win;
      end
      if (grant_fetch) begin
        rom_address_q <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
        rr_q          <= win;
        cur_q         <= win;
      end
      if (complete) begin
        ack_q[cur_q] <= ~ack_q[cur_q];
        load_q       <= 1'b1;
        load_index_q <= cur_q;
        load_data_q  <= bus.rom_data;
      end
    end
  end

  // ROM request toggle, flipped once per fetch grant
  always_ff @(posedge clk) begin
    if (!reset && grant_fetch) rom_req_q <= ~rom_req_q;
  end

  assign bus.ack_toggle  = ack_q;
  assign bus.load        = load_q;
  assign bus.load_index  = load_index_q;
  assign bus.load_data   = load_data_q;
  assign bus.rom_address = rom_address_q;
  assign bus.rom_req     = rom_req_q;
  assign bus.busy        = (state_q != IDLE);
endmodule
